// File: rtl/can_tx_if.sv
// Byte-source / bus-pin side signals of the CAN transmitter.
// The master drives the request and bit tick; the slave (can_tx) drives the pin and status.
interface can_tx_if;
  logic        T_frame;
  logic        Can_tx_start;
  logic [10:0] Can_tx_id;
  logic [7:0]  Can_tx_data_Bus;
  logic        Can_tx;
  logic        Can_tx_busy;
  logic        Can_tx_done;

  modport master (
    output T_frame, Can_tx_start, Can_tx_id, Can_tx_data_Bus,
    input  Can_tx, Can_tx_busy, Can_tx_done
  );

  modport slave (
    input  T_frame, Can_tx_start, Can_tx_id, Can_tx_data_Bus,
    output Can_tx, Can_tx_busy, Can_tx_done
  );
endinterface

// File: rtl/can_tx.sv
// CAN 2.0A transmitter: one standard-ID frame with a single data byte.
// Bits advance only on T_frame; CRC-15 and bit stuffing are generated inline.
module can_tx #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned EOF_BITS  = 7,
  parameter int unsigned IFS_BITS  = 3
) (
  input logic     clock,
  input logic     reset,
  can_tx_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StSof, StArb, StCtl, StData, StCrc, StCrcDel, StAck, StAckDel, StEof, StIfs
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] id_q, id_d;
  logic [7:0]  data_q, data_d;
  logic [14:0] crc_q, crc_d;
  logic [3:0]  run_q, run_d;
  logic        last_q, last_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        bit_val;
  logic        field_end;
  state_e      next_field;
  logic        in_stuff;
  logic        in_crc;
  logic        stuff_now;

  // Stuffing covers SOF..CRC; a stuff bit owed after the last CRC bit is paid in CRC_DEL.
  assign in_stuff  = state_q inside {StSof, StArb, StCtl, StData, StCrc};
  assign in_crc    = state_q inside {StSof, StArb, StCtl, StData};
  assign stuff_now = (in_stuff || (state_q == StCrcDel)) && (run_q == 4'(STUFF_LEN));

  // Per-field decode: the unstuffed bit to send now, whether it closes the field, and what follows.
  always_comb begin
    bit_val    = 1'b1;
    field_end  = 1'b1;
    next_field = StIdle;
    unique case (state_q)
      StSof:    begin bit_val = 1'b0; next_field = StArb; end
      StArb:    begin
        bit_val    = (cnt_q < 8'd11) ? id_q[10] : 1'b0;  // RTR follows the 11 ID bits
        field_end  = (cnt_q == 8'd11);
        next_field = StCtl;
      end
      StCtl:    begin
        bit_val    = (cnt_q == 8'd5);                    // IDE, r0, DLC = 0001
        field_end  = (cnt_q == 8'd5);
        next_field = StData;
      end
      StData:   begin bit_val = data_q[7]; field_end = (cnt_q == 8'd7); next_field = StCrc; end
      StCrc:    begin bit_val = crc_q[14]; field_end = (cnt_q == 8'd14); next_field = StCrcDel; end
      StCrcDel: next_field = StAck;
      StAck:    next_field = StAckDel;
      StAckDel: next_field = StEof;
      StEof:    begin field_end = (cnt_q == 8'(EOF_BITS - 1)); next_field = StIfs; end
      StIfs:    begin field_end = (cnt_q == 8'(IFS_BITS - 1)); next_field = StIdle; end
      default:  ;
    endcase
  end

  // Next-state: accept requests in IDLE, otherwise emit one bit per tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    data_d  = data_q;
    crc_d   = crc_q;
    run_d   = run_q;
    last_d  = last_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      if (bus.Can_tx_start) begin
        id_d    = bus.Can_tx_id;
        data_d  = bus.Can_tx_data_Bus;
        crc_d   = '0;
        cnt_d   = '0;
        run_d   = '0;
        last_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = StSof;
      end
    end else if (bus.T_frame) begin
      if (stuff_now) begin
        // Stuff bit: field counter and CRC hold, run restarts on the new value.
        tx_d   = ~last_q;
        last_d = ~last_q;
        run_d  = 4'd1;
      end else begin
        tx_d = bit_val;
        if (in_stuff) begin
          run_d  = (bit_val == last_q && run_q != 4'd0) ? run_q + 4'd1 : 4'd1;
          last_d = bit_val;
        end
        if (in_crc) begin
          crc_d = {crc_q[13:0], 1'b0} ^ ((bit_val ^ crc_q[14]) ? 15'h4599 : 15'h0000);
        end
        if (state_q == StArb)  id_d   = {id_q[9:0], 1'b0};
        if (state_q == StData) data_d = {data_q[6:0], 1'b0};
        if (state_q == StCrc)  crc_d  = {crc_q[13:0], 1'b0};
        if (field_end) begin
          state_d = next_field;
          cnt_d   = '0;
          if (state_q == StIfs) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  // State register with synchronous reset; a reset mid-frame drops the frame silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      crc_q   <= '0;
      run_q   <= '0;
      last_q  <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      run_q   <= run_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Can_tx      = tx_q;
  assign bus.Can_tx_busy = busy_q;
  assign bus.Can_tx_done = done_q;

endmodule

// File: tb/tb_can_tx.sv
// Scoreboard bench for can_tx: a reference model builds each frame's bit stream,
// and a monitor checks every emitted bit, the busy flag and the done pulse.
module tb_can_tx;
  localparam int STUFF = 5;
  localparam int EOFN  = 7;
  localparam int IFSN  = 3;

  logic clock = 1'b0;
  logic reset;
  can_tx_if bus();

  can_tx #(.STUFF_LEN(STUFF), .EOF_BITS(EOFN), .IFS_BITS(IFSN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];    // expected emitted bits of the frame in flight
  bit got[$];      // bits actually seen on the pin for the current frame
  bit golden[$];   // unstuffed frame
  bit stuffed[$];  // frame as it should appear on the wire
  int stuff_cnt;
  bit prev_exp = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: field layout, bitwise CRC-15, then wire-level stuffing.
  task automatic build(input logic [10:0] id, input logic [7:0] d);
    int unsigned c;
    int run;
    bit last, nxt;
    golden = {};
    stuffed = {};
    stuff_cnt = 0;
    golden.push_back(1'b0);
    for (int i = 10; i >= 0; i--) golden.push_back(id[i]);
    repeat (3) golden.push_back(1'b0);               // RTR, IDE, r0
    golden.push_back(1'b0); golden.push_back(1'b0);  // DLC = 0001
    golden.push_back(1'b0); golden.push_back(1'b1);
    for (int i = 7; i >= 0; i--) golden.push_back(d[i]);
    c = 0;
    foreach (golden[i]) begin
      nxt = golden[i] ^ c[14];
      c = (c << 1) & 32'h7fff;
      if (nxt) c = c ^ 32'h4599;
    end
    for (int i = 14; i >= 0; i--) golden.push_back(c[i]);
    run = 0;
    last = 1'b1;
    foreach (golden[i]) begin
      if (run == STUFF) begin
        stuffed.push_back(!last); last = !last; run = 1; stuff_cnt++;
      end
      stuffed.push_back(golden[i]);
      run = (golden[i] == last) ? run + 1 : 1;
      last = golden[i];
    end
    if (run == STUFF) begin
      stuffed.push_back(!last); stuff_cnt++;
    end
    repeat (3 + EOFN + IFSN) begin
      golden.push_back(1'b1);
      stuffed.push_back(1'b1);
    end
  endtask

  // Monitor: sample pre-edge inputs, then judge the registered outputs just after the edge.
  always @(posedge clock) begin
    bit rst_s, tick_s, busy_s, e;
    rst_s  = reset;
    tick_s = bus.T_frame;
    busy_s = bus.Can_tx_busy;
    #1;
    if (rst_s) begin
      exp_q.delete();
      chk("reset_tx", bus.Can_tx, 1);
      chk("reset_busy", bus.Can_tx_busy, 0);
      chk("reset_done", bus.Can_tx_done, 0);
    end else if (busy_s && tick_s) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        got.push_back(bus.Can_tx);
        chk($sformatf("bit%0d", got.size() - 1), bus.Can_tx, e);
        chk("done_flag", bus.Can_tx_done, exp_q.size() == 0);
        chk("busy_flag", bus.Can_tx_busy, exp_q.size() != 0);
        prev_exp = e;
      end
    end else if (busy_s) begin
      chk("hold_tx", bus.Can_tx, prev_exp);
      chk("hold_done", bus.Can_tx_done, 0);
    end else begin
      chk("idle_tx", bus.Can_tx, 1);
      chk("idle_done", bus.Can_tx_done, 0);
    end
  end

  // One input cycle; tk < 0 gives a random tick, otherwise tk[0] is forced.
  task automatic drive(input bit st, input logic [10:0] id, input logic [7:0] d, input int tk);
    @(negedge clock);
    bus.Can_tx_start = st;
    if (st) begin
      bus.Can_tx_id = id;
      bus.Can_tx_data_Bus = d;
    end
    bus.T_frame = (tk < 0) ? ($urandom_range(0, 2) != 0) : tk[0];
  endtask

  task automatic send(input logic [10:0] id, input logic [7:0] d, input int tk);
    int guard = 0;
    while ((bus.Can_tx_busy || exp_q.size() != 0) && guard < 1000) begin
      drive(0, 0, 0, -1);
      guard++;
    end
    if (guard >= 1000) chk("send_wait_timeout", 1, 0);
    drive(1, id, d, tk);
    build(id, d);
    exp_q = stuffed;
    prev_exp = 1'b1;
    got = {};
  endtask

  task automatic finish_frame();
    int guard = 0;
    do begin
      drive(0, 0, 0, -1);
      guard++;
    end while ((bus.Can_tx_busy || exp_q.size() != 0) && guard < 1000);
    if (guard >= 1000) chk("frame_timeout", 1, 0);
  endtask

  // Remove stuff bits from what the pin carried and compare against the unstuffed model frame.
  task automatic check_destuffed(input string name);
    bit dest[$];
    int run = 0;
    int k = 0;
    int bad = 0;
    bit last = 1'b1;
    foreach (got[i]) begin
      if (k <= 42 && run == STUFF) begin
        last = got[i]; run = 1;
      end else begin
        if (k < 42) begin
          run = (got[i] == last) ? run + 1 : 1;
          last = got[i];
        end
        dest.push_back(got[i]);
        k++;
      end
    end
    chk({name, "_len"}, dest.size(), golden.size());
    foreach (golden[i]) if (i >= dest.size() || dest[i] != golden[i]) bad++;
    chk({name, "_bits"}, bad, 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    bus.T_frame = 1'b0;
    bus.Can_tx_start = 1'b0;
    bus.Can_tx_id = '0;
    bus.Can_tx_data_Bus = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle with ticks: pin stays recessive, no done.
    repeat (20) drive(0, 0, 0, 1);
    chk("idle_busy", bus.Can_tx_busy, 0);

    // Alternating pattern: one stuff bit right after DLC2.
    send(11'h555, 8'h55, -1);
    finish_frame();
    chk("f555_len", got.size(), 55 + stuff_cnt);
    if (got.size() > 17) chk("f555_stuff17", got[17], 1);
    check_destuffed("f555");

    // All zeros: a 1 is stuffed as the 6th emitted bit.
    send(11'h000, 8'h00, -1);
    finish_frame();
    chk("f000_len", got.size(), 55 + stuff_cnt);
    if (got.size() > 5) chk("f000_stuff5", got[5], 1);
    check_destuffed("f000");

    // Start during an active frame is ignored; the following request goes out normally.
    send(11'h3a5, 8'hc3, -1);
    guard = 0;
    while (got.size() < 10 && guard < 200) begin drive(0, 0, 0, 1); guard++; end
    drive(1, 11'h12f, 8'h9e, 1);
    finish_frame();
    check_destuffed("busy_start");
    send(11'h12f, 8'h9e, -1);
    finish_frame();
    check_destuffed("after_busy");

    // Start coinciding with a tick: only latched, SOF waits for the next tick.
    send(11'h7ff, 8'hff, 1);
    drive(0, 0, 0, 0);
    @(posedge clock); #1;
    chk("same_cycle_hold", bus.Can_tx, 1);
    drive(0, 0, 0, 1);
    @(posedge clock); #1;
    chk("same_cycle_sof", bus.Can_tx, 0);
    finish_frame();
    check_destuffed("f7ff");

    // Reset inside the DATA field, then a clean frame.
    send(11'h2c6, 8'ha7, -1);
    guard = 0;
    while (got.size() < 24 && guard < 200) begin drive(0, 0, 0, 1); guard++; end
    @(negedge clock);
    reset = 1'b1;
    bus.T_frame = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (5) drive(0, 0, 0, 1);
    chk("post_reset_busy", bus.Can_tx_busy, 0);
    send(11'h2c6, 8'ha7, -1);
    finish_frame();
    check_destuffed("post_reset");

    // Random frames.
    repeat (8) begin
      logic [10:0] rid;
      logic [7:0]  rd;
      rid = 11'($urandom);
      rd  = 8'($urandom);
      send(rid, rd, -1);
      finish_frame();
      chk("rand_len", got.size(), 55 + stuff_cnt);
    end

    repeat (5) drive(0, 0, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/can_tx.md
Name: can_tx

Overview:
- Serialises one single-byte CAN 2.0A data frame (standard 11-bit ID, DLC=1) onto the bus line. It is the transmit counterpart of the bridge's CAN receiver.
- Sits between the UART-side byte source and the CAN pin. Bit timing comes from an external per-bit tick, the same way the receiver is paced.
- Generates CRC-15 and performs bit stuffing. It does not monitor ACK or arbitration; it transmits recessive in the ACK slot and never aborts.

Parameters:
- STUFF_LEN, 5, number of identical consecutive bits after which a complement stuff bit is inserted.
- EOF_BITS, 7, recessive end-of-frame bits.
- IFS_BITS, 3, recessive intermission bits before the block can accept the next frame.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- T_frame  input  1  one-cycle bit tick; the output bit advances only on cycles where this is 1.
- Can_tx_start  input  1  request to send; sampled only in IDLE.
- Can_tx_id  input  11  identifier; latched with start.
- Can_tx_data_Bus  input  8  data byte; latched with start.
- Can_tx  output  1  serial bus bit; 1 = recessive.
- Can_tx_busy  output  1  high from the cycle after start is accepted until the frame completes.
- Can_tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high.
- Reset values: Can_tx=1, Can_tx_busy=0, Can_tx_done=0, state=IDLE, counters=0, CRC=0.
- Reset asserted mid-frame: on the next edge Can_tx=1, busy=0, no done pulse; the latched frame is discarded.
- Accepting a request: in IDLE, Can_tx_start=1 latches ID and data and moves to SOF. Can_tx_busy=1 from the next cycle.
- Start while busy is ignored and the latched inputs are unchanged.
- Start and T_frame in the same IDLE cycle: the request is only latched. SOF is driven on the next T_frame.
- Timing: every state transition and Can_tx update happens on a T_frame cycle. Can_tx is registered and holds its value between ticks.
- Frame bit order, MSB first within each field:
  - SOF: 0.
  - ID: 11 bits.
  - RTR: 0.
  - IDE: 0.
  - r0: 0.
  - DLC: 0001.
  - DATA: 8 bits.
  - CRC: 15 bits.
  - CRC_DEL: 1.
  - ACK: 1.
  - ACK_DEL: 1.
  - EOF: EOF_BITS ones.
  - IFS: IFS_BITS ones.
- States: IDLE, SOF, ARB (ID+RTR), CTL (IDE, r0, DLC), DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS.
  - A per-field bit counter advances on each unstuffed data tick.
  - The field transition happens on the tick that emits the field's last bit.
- CRC-15:
  - Polynomial 0x4599, initial value 0.
  - Updated once per unstuffed bit from SOF through the last DATA bit; stuff bits are excluded.
  - The CRC field shifts out the final register value MSB first.
- Bit stuffing:
  - Active from SOF through the last CRC bit.
  - Track the last emitted bit and a run length; stuff bits count in the run.
  - After STUFF_LEN identical emitted bits, the next tick emits the complement instead. The field counter and CRC do not advance, and the run resets to 1 of the new value.
  - A stuff bit due after the final CRC bit is still emitted before CRC_DEL.
  - No stuffing from CRC_DEL onward.
- Completion: on the tick that ends the last IFS bit, Can_tx_done=1 for one cycle, busy=0 in the same cycle, and the state returns to IDLE.
- Frame length: unstuffed frame = 42 + 3 + EOF_BITS + IFS_BITS = 55 ticks at default parameters, plus one tick per stuff bit.

Test Plan:
- Reset, then 20 ticks with no start -> Can_tx=1, busy=0, done never pulses.
- ID=0x555, data=0x55 -> SOF 0; ID bits 10101010101; RTR/IDE/r0/DLC3/DLC2 all 0; exactly one stuff bit of value 1 after DLC2 (before the CRC field); then DLC1=0, DLC0=1, data 01010101. CRC field, delimiters and the 7+3 recessive bits match the bench golden model.
- ID=0x000, data=0x00 -> stuff 1 after every 5 zeros, e.g. a 1 at the 6th emitted bit. The decoded (destuffed) stream equals the golden frame, and the done pulse falls exactly at 55 + stuff-count ticks.
- Can_tx_start pulsed at tick 10 of an active frame with different ID/data -> the frame is unchanged; after done, a new start sends the new frame normally.
- Start and T_frame in the same cycle -> Can_tx stays 1 until the next T_frame, then 0 (SOF).
- Reset asserted during DATA -> Can_tx=1 next edge, busy=0, no done pulse; a subsequent start transmits a full correct frame.
